// File: rtl/seq_match_window_counter_if.sv
// Port bundle for seq_match_window_counter: run control, the match pulse,
// the result handshake and the status flags.
interface seq_match_window_counter_if #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [WIN_W-1:0] window_len;
  logic             match;
  logic             res_ready;
  logic             res_valid;
  logic [CNT_W-1:0] res_count;
  logic             res_sat;
  logic             overrun;
  logic             busy;
  logic             dbg_state;

  // Handshake: a result transfers on a cycle with res_valid && res_ready.
  // While res_valid is high and res_ready is low, res_count and res_sat hold.
  modport master (
    input  en, window_len, match, res_ready,
    output res_valid, res_count, res_sat, overrun, busy, dbg_state
  );

  modport slave (
    output en, window_len, match, res_ready,
    input  res_valid, res_count, res_sat, overrun, busy, dbg_state
  );
endinterface

// File: rtl/seq_match_window_counter.sv
// Counts match pulses over back-to-back programmable windows and hands each
// window's count to a single-entry valid/ready result register.
module seq_match_window_counter #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8
) (
  input logic                          clk,
  input logic                          reset,
  seq_match_window_counter_if.master   bus
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             sat_acc_q, sat_acc_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             res_sat_q, res_sat_d;
  logic             overrun_q, overrun_d;

  logic             last_cycle;
  logic             res_fire;
  logic [WIN_W-1:0] len_start;
  logic [CNT_W-1:0] acc_next;
  logic             sat_next;

  assign last_cycle = (timer_q == len_q - WIN_W'(1));
  assign res_fire   = res_valid_q & bus.res_ready;
  assign len_start  = (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;

  // Accumulator including this cycle's match, saturating at all-ones.
  always_comb begin
    acc_next = acc_q;
    sat_next = sat_acc_q;
    if (bus.match) begin
      if (acc_q == ACC_MAX) begin
        sat_next = 1'b1;
      end else begin
        acc_next = acc_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    len_d       = len_q;
    acc_d       = acc_q;
    sat_acc_d   = sat_acc_q;
    res_valid_d = res_valid_q & ~res_fire;
    res_count_d = res_count_q;
    res_sat_d   = res_sat_q;
    overrun_d   = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d   = COUNT;
          len_d     = len_start;
          timer_d   = '0;
          acc_d     = '0;
          sat_acc_d = 1'b0;
          overrun_d = 1'b0;
        end
      end
      COUNT: begin
        if (last_cycle) begin
          // A load in the same cycle as a consume wins over the clear.
          if (!res_valid_q || res_fire) begin
            res_valid_d = 1'b1;
            res_count_d = acc_next;
            res_sat_d   = sat_next;
          end else begin
            overrun_d = 1'b1;
          end
          if (bus.en) begin
            len_d     = len_start;
            timer_d   = '0;
            acc_d     = '0;
            sat_acc_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (!bus.en) begin
          state_d = IDLE;
        end else begin
          timer_d   = timer_q + WIN_W'(1);
          acc_d     = acc_next;
          sat_acc_d = sat_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      len_q       <= WIN_W'(1);
      acc_q       <= '0;
      sat_acc_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_count_q <= '0;
      res_sat_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      sat_acc_q   <= sat_acc_d;
      res_valid_q <= res_valid_d;
      res_count_q <= res_count_d;
      res_sat_q   <= res_sat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_count = res_count_q;
  assign bus.res_sat   = res_sat_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q == COUNT);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_seq_match_window_counter.sv
// Bench for seq_match_window_counter: directed scenarios followed by random
// traffic, all checked against a window-level reference model.
module tb_seq_match_window_counter;

  localparam int WIN_W   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  seq_match_window_counter_if #(.WIN_W(WIN_W), .CNT_W(CNT_W)) bus ();

  seq_match_window_counter #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a window is "len cycles seen, m matches seen"; the
  // reported count is min(m, max) and sat means m exceeded the max.
  bit m_busy;
  int m_len, m_n, m_matches;
  bit m_rv, m_rs, m_ovr;
  int m_rc;

  task automatic model_reset();
    m_busy = 0; m_len = 1; m_n = 0; m_matches = 0;
    m_rv = 0; m_rc = 0; m_rs = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit e, input int wl, input bit m, input bit r);
    bit fire;
    fire = m_rv && r;
    if (fire) m_rv = 0;
    if (!m_busy) begin
      if (e) begin
        m_busy = 1; m_len = (wl == 0) ? 1 : wl; m_n = 0; m_matches = 0; m_ovr = 0;
      end
    end else begin
      m_n++;
      m_matches += m;
      if (m_n == m_len) begin
        if (!(m_rv && !fire) ) begin
          m_rv = 1;
          m_rc = (m_matches > CNT_MAX) ? CNT_MAX : m_matches;
          m_rs = (m_matches > CNT_MAX);
        end else begin
          m_ovr = 1;
        end
        if (e) begin
          m_len = (wl == 0) ? 1 : wl; m_n = 0; m_matches = 0;
        end else begin
          m_busy = 0;
        end
      end else if (!e) begin
        m_busy = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, ".res_valid"}, 32'(bus.res_valid), 32'(m_rv));
    check_val({tag, ".res_count"}, 32'(bus.res_count), 32'(m_rc));
    check_val({tag, ".res_sat"},   32'(bus.res_sat),   32'(m_rs));
    check_val({tag, ".overrun"},   32'(bus.overrun),   32'(m_ovr));
    check_val({tag, ".busy"},      32'(bus.busy),      32'(m_busy));
    check_val({tag, ".dbg_state"}, 32'(bus.dbg_state), 32'(m_busy));
  endtask

  // Drive one cycle's inputs just after a falling edge, advance the model,
  // then check outputs at the next falling edge.
  task automatic step(input bit e, input int wl, input bit m, input bit r, input string tag);
    bus.en         = e;
    bus.window_len = WIN_W'(wl);
    bus.match      = m;
    bus.res_ready  = r;
    model_step(e, wl, m, r);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic drain();
    step(0, 0, 0, 1, "drain");
    step(0, 0, 0, 1, "drain");
  endtask

  initial begin
    int nres;
    bit mb;
    reset          = 1'b1;
    bus.en         = 1'b0;
    bus.window_len = '0;
    bus.match      = 1'b0;
    bus.res_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all("reset");

    // Asynchronous reset mid-window while a result is pending.
    step(1, 2, 0, 0, "t1");
    step(1, 2, 1, 0, "t1");
    step(1, 2, 0, 0, "t1");
    step(1, 2, 1, 0, "t1");
    check_val("t1_pending", 32'(bus.res_valid), 32'd1);
    #2 reset = 1'b1;
    #1 model_reset();
    compare_all("t1_async");
    check_val("t1_async_valid", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    bus.en = 1'b0;
    reset  = 1'b0;
    compare_all("t1_release");
    for (int i = 0; i < 3; i++) begin
      step(0, 5, 1, 0, "t1_idle");
      check_val("t1_busy", 32'(bus.busy), 32'd0);
    end

    // Window of 8 with matches on cycles 1, 4, 7; result held until consumed.
    step(1, 8, 0, 0, "t2");
    for (int w = 1; w <= 8; w++)
      step(w != 8, 8, (w == 1 || w == 4 || w == 7), 0, "t2");
    for (int i = 0; i < 3; i++) begin
      check_val("t2_valid", 32'(bus.res_valid), 32'd1);
      check_val("t2_count", 32'(bus.res_count), 32'd3);
      check_val("t2_sat",   32'(bus.res_sat),   32'd0);
      step(0, 8, 0, 0, "t2_hold");
    end
    step(0, 8, 0, 1, "t2_take");
    check_val("t2_cleared", 32'(bus.res_valid), 32'd0);

    // Back-to-back windows of 4, every cycle a match, consumer always ready.
    step(1, 4, 1, 1, "t3");
    nres = 0;
    for (int i = 0; i < 12; i++) begin
      step(i != 11, 4, 1, 1, "t3");
      if (bus.res_valid) begin
        nres++;
        check_val("t3_count",   32'(bus.res_count), 32'd4);
        check_val("t3_spacing", 32'(i % 4), 32'd3);
      end
    end
    check_val("t3_results", 32'(nres), 32'd3);

    // Two windows of 3 with no consumer: second result lost, overrun sticks.
    drain();
    step(1, 3, 0, 0, "t4");
    step(1, 3, 1, 0, "t4");
    step(1, 3, 0, 0, "t4");
    step(1, 3, 0, 0, "t4");
    step(1, 3, 1, 0, "t4");
    step(1, 3, 1, 0, "t4");
    step(0, 3, 0, 0, "t4");
    check_val("t4_kept",    32'(bus.res_count), 32'd1);
    check_val("t4_overrun", 32'(bus.overrun),   32'd1);
    for (int i = 0; i < 3; i++) step(0, 3, 0, 1, "t4_idle");
    check_val("t4_sticky", 32'(bus.overrun), 32'd1);
    step(1, 3, 0, 1, "t4_restart");
    check_val("t4_cleared", 32'(bus.overrun), 32'd0);
    step(0, 3, 0, 1, "t4_abort");

    // Saturation over a 20-cycle window, then an unsaturated window of 4.
    drain();
    step(1, 20, 1, 0, "t5");
    for (int w = 1; w <= 20; w++) step(1, (w == 20) ? 4 : 20, 1, 0, "t5");
    check_val("t5_sat_count", 32'(bus.res_count), 32'(CNT_MAX));
    check_val("t5_sat_flag",  32'(bus.res_sat),   32'd1);
    step(1, 4, 1, 1, "t5");
    step(1, 4, 0, 0, "t5");
    step(1, 4, 1, 0, "t5");
    step(0, 4, 0, 0, "t5");
    check_val("t5_count", 32'(bus.res_count), 32'd2);
    check_val("t5_flag",  32'(bus.res_sat),   32'd0);

    // Abort on window cycle 2, then 1-cycle windows from window_len=0.
    drain();
    step(1, 5, 0, 0, "t6");
    step(1, 5, 1, 0, "t6");
    step(0, 5, 1, 0, "t6_abort");
    check_val("t6_busy",  32'(bus.busy),      32'd0);
    check_val("t6_noval", 32'(bus.res_valid), 32'd0);
    step(1, 0, 0, 1, "t6");
    for (int i = 0; i < 8; i++) begin
      mb = 1'($urandom_range(0, 1));
      step(i != 7, 0, mb, 1, "t6_len1");
      check_val("t6_len1_valid", 32'(bus.res_valid), 32'd1);
      check_val("t6_len1_count", 32'(bus.res_count), 32'(mb));
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int wl;
      wl = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
      step($urandom_range(0, 19) != 0, wl, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_match_window_counter.md
Name: seq_match_window_counter

Overview:
- Downstream consumer of the sequence-detector match pulse (1-cycle Mealy output).
- Counts detected matches over consecutive programmable windows of clock cycles.
- Presents each window's count through a valid/ready result register and flags lost results (overrun) and saturated counts.
- Feeds status/readout logic.

Parameters:
- WIN_W, 8, width of window_len and the internal window timer.
- CNT_W, 8, width of the match accumulator and res_count.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  run enable; windows run back-to-back while high.
- window_len  input  WIN_W  window length in cycles; sampled at each window start; 0 is treated as 1.
- match  input  1  match pulse from the sequence detector; each high cycle counts once.
- res_ready  input  1  consumer accepts the result.
- res_valid  output  1  result register holds an unconsumed window count.
- res_count  output  CNT_W  match count of the reported window.
- res_sat  output  1  reported window's count saturated.
- overrun  output  1  sticky: a completed window was dropped because the result register was full.
- busy  output  1  high while in COUNT.

Behaviour:
- Reset: asynchronous; returns to state IDLE.
  - res_valid=0, res_count=0, res_sat=0, overrun=0, busy=0.
  - Internal timer=0, acc=0, sat_acc=0, len_q=1.
- States: IDLE, COUNT.
- IDLE:
  - match is ignored.
  - On en=1, latch len_q=max(window_len,1), timer=0, acc=0, sat_acc=0, overrun=0, then go to COUNT.
  - The first counted cycle is the cycle after en is sampled high.
- COUNT:
  - Each cycle, if match=1: acc=acc+1, saturating at 2^CNT_W-1; sat_acc=1 if acc was already at max.
  - The timer increments each cycle.
  - A window spans exactly len_q cycles of match sampling.
- Last window cycle (timer==len_q-1):
  - The final count is acc plus that cycle's match, saturating; sat includes that increment.
  - If the result register is free (res_valid=0, or res_valid&res_ready this same cycle): load res_count and res_sat from the final values and set res_valid=1 next cycle.
  - Otherwise drop the window's result, keep the old result unchanged, and set overrun=1.
  - If en=1: restart immediately with no gap cycle. Relatch len_q from window_len, timer=0, acc=0, sat_acc=0; stay in COUNT.
  - If en=0: go to IDLE.
- en=0 before the last cycle of a window: abort the window and discard the partial count.
  - Go to IDLE next cycle.
  - The result register and overrun are unaffected.
- Result handshake:
  - res_valid&res_ready clears res_valid next cycle unless a new result loads in that same cycle; the new result wins.
  - res_count and res_sat are stable while res_valid=1 and res_ready=0.
  - The result register is independent of state; it is drained in IDLE as well.
- overrun is cleared only by reset or by the IDLE->COUNT transition.
- busy = (state==COUNT).
- window_len changes mid-window have no effect until the next window start.
- Timer width is WIN_W; the maximum window is 2^WIN_W-1 cycles; no timer wrap occurs within a window.

Test Plan:
1. Reset asserted mid-window with res_valid=1 -> all outputs 0 immediately (asynchronous reset); after release with en=0, state stays IDLE and busy=0.
2. window_len=8, en=1, match high on window cycles 1, 4 and 7, res_ready=0 -> res_valid=1 with res_count=3 and res_sat=0, held stable until res_ready=1, then res_valid=0 the cycle after.
3. window_len=4, en=1 for 12 cycles, match=1 every cycle, res_ready=1 -> three results, each res_count=4, spaced exactly 4 cycles apart; no gap cycle between windows.
4. window_len=3, res_ready=0 across two completed windows -> first count retained; overrun=1 after the second window ends; overrun persists until the next IDLE->COUNT.
5. CNT_W=4, window_len=20, match=1 every cycle -> res_count=15, res_sat=1. Next window with 2 matches -> res_count=2, res_sat=0.
6. en dropped on cycle 2 of a window_len=5 window with 2 matches -> no result produced, IDLE next cycle. Then window_len=0 with en=1 -> 1-cycle windows, res_count equals each cycle's match value.
